// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator for the scrolling-background renderer
//
// Ports:
//   clk          pixel-domain clock
//   reset        asynchronous, active-high reset
//   px_en        pixel advance enable (tie high when clk equals the pixel rate)
//   hsync        horizontal sync, active level HS_POL
//   vsync        vertical sync, active level VS_POL
//   x_px         horizontal position, 0..H_TOTAL-1
//   y_px         vertical position, 0..V_TOTAL-1
//   activevideo  high inside the visible H_ACTIVE x V_ACTIVE window
//   line_start   high while x_px == 0
//   frame_start  high while x_px == 0 and y_px == 0
//   frame_count  completed-frame counter, wraps modulo 2^FRAME_W

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int FRAME_W  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               px_en,
  output logic               hsync,
  output logic               vsync,
  output logic [9:0]         x_px,
  output logic [9:0]         y_px,
  output logic               activevideo,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit constants so a total of exactly 1024 is still representable
  localparam logic [10:0] C_H_TOTAL  = 11'(H_TOTAL);
  localparam logic [10:0] C_V_TOTAL  = 11'(V_TOTAL);
  localparam logic [10:0] C_H_ACTIVE = 11'(H_ACTIVE);
  localparam logic [10:0] C_V_ACTIVE = 11'(V_ACTIVE);
  localparam logic [10:0] C_HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] C_VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
  endgenerate

  logic [9:0]         r_x;
  logic [9:0]         r_y;
  logic [FRAME_W-1:0] r_frame;
  logic               r_hsync;
  logic               r_vsync;

  logic [10:0]        w_x_ext;
  logic [10:0]        w_y_ext;
  logic               w_x_wrap;
  logic               w_y_wrap;
  logic [9:0]         w_x_next;
  logic [9:0]         w_y_next;
  logic [10:0]        w_x_next_ext;
  logic [10:0]        w_y_next_ext;
  logic               w_frame_tick;
  logic               w_hs_next;
  logic               w_vs_next;

  always_comb begin
    w_x_ext = {1'b0, r_x};
    w_y_ext = {1'b0, r_y};

    // ">=" rather than "==" so an out-of-range count also reloads 0
    w_x_wrap = (w_x_ext >= C_H_TOTAL - 11'd1);
    w_y_wrap = (w_y_ext >= C_V_TOTAL - 11'd1);

    w_x_next = w_x_wrap ? 10'd0 : r_x + 10'd1;

    if (w_y_ext >= C_V_TOTAL) begin
      w_y_next = 10'd0;
    end else if (w_x_wrap) begin
      w_y_next = w_y_wrap ? 10'd0 : r_y + 10'd1;
    end else begin
      w_y_next = r_y;
    end

    // Only the genuine last pixel of the frame counts as a completed frame
    w_frame_tick = (w_x_ext == C_H_TOTAL - 11'd1) && (w_y_ext == C_V_TOTAL - 11'd1);

    // Syncs are decoded from the next counter values so that, once
    // registered, they line up with the x_px/y_px presented alongside them
    w_x_next_ext = {1'b0, w_x_next};
    w_y_next_ext = {1'b0, w_y_next};
    w_hs_next = ((w_x_next_ext >= C_HS_BEG) && (w_x_next_ext < C_HS_END)) ? HS_POL : ~HS_POL;
    w_vs_next = ((w_y_next_ext >= C_VS_BEG) && (w_y_next_ext < C_VS_END)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= 10'd0;
      r_y     <= 10'd0;
      r_frame <= '0;
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
    end else if (px_en) begin
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_hsync <= w_hs_next;
      r_vsync <= w_vs_next;
      if (w_frame_tick) begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

  assign x_px        = r_x;
  assign y_px        = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_count = r_frame;
  assign activevideo = (w_x_ext < C_H_ACTIVE) && (w_y_ext < C_V_ACTIVE);
  assign line_start  = (r_x == 10'd0);
  assign frame_start = (r_x == 10'd0) && (r_y == 10'd0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen

module tb_vga_timing_gen;

  // Compact geometry instance: 32 x 20 totals, 640 pixels per frame
  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 6, SHT = 32;
  localparam int SVA = 12, SVF = 2, SVS = 2, SVB = 4, SVT = 20;
  // Default 640x480 geometry instance
  localparam int DHT = 800, DVT = 525;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic px_en = 1'b0;

  logic       s_hsync, s_vsync, s_av, s_ls, s_fs;
  logic [9:0] s_x, s_y;
  logic [4:0] s_fc;
  logic       d_hsync, d_vsync, d_av, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic [4:0] d_fc;

  int checks = 0;
  int failures = 0;
  int n = 0;   // pixel advances since the last reset, shared by both instances

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .HS_POL(1'b1), .VS_POL(1'b0), .FRAME_W(5)
  ) u_small (
    .clk(clk), .reset(reset), .px_en(px_en),
    .hsync(s_hsync), .vsync(s_vsync), .x_px(s_x), .y_px(s_y),
    .activevideo(s_av), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing_gen u_default (
    .clk(clk), .reset(reset), .px_en(px_en),
    .hsync(d_hsync), .vsync(d_vsync), .x_px(d_x), .y_px(d_y),
    .activevideo(d_av), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  always #5 clk = ~clk;

  // Reference model: raster position follows directly from the advance count
  function automatic int ex(int k, int ht);
    return k % ht;
  endfunction
  function automatic int ey(int k, int ht, int vt);
    return (k / ht) % vt;
  endfunction
  function automatic int ef(int k, int ht, int vt);
    return (k / (ht * vt)) % 32;
  endfunction
  function automatic bit inwin(int v, int lo, int w);
    return (v >= lo) && (v < lo + w);
  endfunction
  function automatic bit s_hs_exp(int k);
    return inwin(ex(k, SHT), SHA + SHF, SHS);          // active-high
  endfunction
  function automatic bit s_vs_exp(int k);
    return !inwin(ey(k, SHT, SVT), SVA + SVF, SVS);    // active-low
  endfunction

  task automatic tick();
    bit r;
    bit e;
    r = reset;
    e = px_en;
    @(posedge clk);
    #1;
    if (r) n = 0;
    else if (e) n++;
  endtask

  task automatic run(int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic restart();
    reset = 1'b1;
    px_en = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    px_en = 1'b1;
    run(3);
    checks++; if (s_x !== 10'd0) begin failures++; $display("FAIL reset_x got=%0d exp=0", s_x); end
    checks++; if (s_y !== 10'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", s_y); end
    checks++; if (s_fc !== 5'd0) begin failures++; $display("FAIL reset_fc got=%0d exp=0", s_fc); end
    checks++; if (s_hsync !== 1'b0) begin failures++; $display("FAIL reset_s_hsync got=%b exp=0", s_hsync); end
    checks++; if (s_vsync !== 1'b1) begin failures++; $display("FAIL reset_s_vsync got=%b exp=1", s_vsync); end
    checks++; if (d_hsync !== 1'b1) begin failures++; $display("FAIL reset_d_hsync got=%b exp=1", d_hsync); end
    checks++; if (d_vsync !== 1'b1) begin failures++; $display("FAIL reset_d_vsync got=%b exp=1", d_vsync); end
    checks++; if ({s_av, s_ls, s_fs} !== 3'b111) begin failures++; $display("FAIL reset_strobes got=%b exp=111", {s_av, s_ls, s_fs}); end
    checks++; if ({d_x, d_y, d_fc} !== 25'd0) begin failures++; $display("FAIL reset_d_counters got=%0d,%0d,%0d exp=0,0,0", d_x, d_y, d_fc); end
  endtask

  task automatic test_hsync_line();
    restart();
    for (int i = 1; i <= DHT; i++) begin
      tick();
      checks++;
      if (d_hsync !== !inwin(ex(n, DHT), 656, 96)) begin
        failures++; $display("FAIL line_hsync n=%0d got=%b exp=%b", n, d_hsync, !inwin(ex(n, DHT), 656, 96));
      end
      checks++;
      if (d_av !== (ex(n, DHT) < 640)) begin
        failures++; $display("FAIL line_active n=%0d got=%b exp=%b", n, d_av, ex(n, DHT) < 640);
      end
      if (i == 656) begin
        checks++; if (d_x !== 10'd656 || d_hsync !== 1'b0) begin failures++; $display("FAIL hsync_begin got x=%0d hs=%b exp x=656 hs=0", d_x, d_hsync); end
      end
      if (i == 752) begin
        checks++; if (d_hsync !== 1'b1) begin failures++; $display("FAIL hsync_end got=%b exp=1", d_hsync); end
      end
      if (i == DHT - 1) begin
        checks++; if (d_x !== 10'd799 || d_y !== 10'd0) begin failures++; $display("FAIL line_last got=%0d,%0d exp=799,0", d_x, d_y); end
      end
    end
    checks++; if (d_x !== 10'd0 || d_y !== 10'd1) begin failures++; $display("FAIL line_wrap got=%0d,%0d exp=0,1", d_x, d_y); end
    checks++; if ({d_ls, d_fs} !== 2'b10) begin failures++; $display("FAIL line_wrap_strobes got=%b exp=10", {d_ls, d_fs}); end
    checks++; if (d_fc !== 5'd0) begin failures++; $display("FAIL line_wrap_fc got=%0d exp=0", d_fc); end
  endtask

  task automatic test_frame();
    int vs_low;
    logic prev_vs;
    restart();
    vs_low = 0;
    prev_vs = s_vsync;
    for (int i = 0; i < SHT * SVT; i++) begin
      checks++;
      if (s_x !== 10'(ex(n, SHT)) || s_y !== 10'(ey(n, SHT, SVT))) begin
        failures++; $display("FAIL frame_xy n=%0d got=%0d,%0d exp=%0d,%0d", n, s_x, s_y, ex(n, SHT), ey(n, SHT, SVT));
      end
      checks++;
      if (s_hsync !== s_hs_exp(n) || s_vsync !== s_vs_exp(n)) begin
        failures++; $display("FAIL frame_sync n=%0d got=%b%b exp=%b%b", n, s_hsync, s_vsync, s_hs_exp(n), s_vs_exp(n));
      end
      checks++;
      if (s_av !== (ex(n, SHT) < SHA && ey(n, SHT, SVT) < SVA) ||
          s_ls !== (ex(n, SHT) == 0) || s_fs !== (ex(n, SHT) == 0 && ey(n, SHT, SVT) == 0)) begin
        failures++; $display("FAIL frame_decode n=%0d got=%b%b%b", n, s_av, s_ls, s_fs);
      end
      if (s_vsync !== prev_vs) begin
        checks++; if (s_x !== 10'd0) begin failures++; $display("FAIL vsync_edge_x got=%0d exp=0", s_x); end
      end
      prev_vs = s_vsync;
      if (s_vsync === 1'b0) vs_low++;
      tick();
    end
    checks++; if (vs_low != SVS * SHT) begin failures++; $display("FAIL vsync_width got=%0d exp=%0d", vs_low, SVS * SHT); end
  endtask

  task automatic test_frame_wrap();
    restart();
    run(SHT * SVT - 1);
    checks++; if (s_x !== 10'(SHT - 1) || s_y !== 10'(SVT - 1) || s_fc !== 5'd0) begin
      failures++; $display("FAIL frame_last got=%0d,%0d,%0d exp=%0d,%0d,0", s_x, s_y, s_fc, SHT - 1, SVT - 1);
    end
    tick();
    checks++; if (s_x !== 10'd0 || s_y !== 10'd0 || s_fs !== 1'b1 || s_fc !== 5'd1) begin
      failures++; $display("FAIL frame_wrap got=%0d,%0d fs=%b fc=%0d exp=0,0 fs=1 fc=1", s_x, s_y, s_fs, s_fc);
    end
    for (int i = 0; i < 31 * SHT * SVT; i++) begin
      tick();
      checks++;
      if (s_fc !== 5'(ef(n, SHT, SVT))) begin
        failures++; $display("FAIL frame_count n=%0d got=%0d exp=%0d", n, s_fc, ef(n, SHT, SVT));
      end
    end
    checks++; if (s_fc !== 5'd0 || s_fs !== 1'b1) begin failures++; $display("FAIL frame_count_wrap got=%0d fs=%b exp=0 fs=1", s_fc, s_fs); end
  endtask

  task automatic test_px_en();
    restart();
    run(3 * SHT + 10);
    checks++; if (s_x !== 10'd10 || s_y !== 10'd3) begin failures++; $display("FAIL en_start got=%0d,%0d exp=10,3", s_x, s_y); end
    for (int i = 0; i < 20; i++) begin
      px_en = (i % 2 == 0);
      tick();
      checks++;
      if (s_x !== 10'(ex(n, SHT)) || s_y !== 10'(ey(n, SHT, SVT)) || s_hsync !== s_hs_exp(n) ||
          s_vsync !== s_vs_exp(n) || s_av !== (ex(n, SHT) < SHA) || s_ls !== 1'b0 || s_fc !== 5'd0) begin
        failures++; $display("FAIL en_toggle i=%0d got x=%0d hs=%b av=%b exp x=%0d", i, s_x, s_hsync, s_av, ex(n, SHT));
      end
    end
    checks++; if (s_x !== 10'd20) begin failures++; $display("FAIL en_end_x got=%0d exp=20", s_x); end
    px_en = 1'b1;
    run(SHT - ex(n, SHT));
    px_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (s_ls !== 1'b1 || s_x !== 10'd0) begin failures++; $display("FAIL strobe_hold got ls=%b x=%0d exp ls=1 x=0", s_ls, s_x); end
    end
    px_en = 1'b1;
    tick();
    checks++; if (s_ls !== 1'b0 || s_x !== 10'd1) begin failures++; $display("FAIL strobe_release got ls=%b x=%0d exp ls=0 x=1", s_ls, s_x); end
  endtask

  task automatic test_random_enable();
    restart();
    for (int i = 0; i < 3000; i++) begin
      px_en = ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (s_x !== 10'(ex(n, SHT)) || s_y !== 10'(ey(n, SHT, SVT)) || s_fc !== 5'(ef(n, SHT, SVT)) ||
          s_hsync !== s_hs_exp(n) || s_vsync !== s_vs_exp(n) ||
          s_av !== (ex(n, SHT) < SHA && ey(n, SHT, SVT) < SVA) ||
          s_fs !== (ex(n, SHT) == 0 && ey(n, SHT, SVT) == 0)) begin
        failures++; $display("FAIL random n=%0d got x=%0d y=%0d fc=%0d exp x=%0d y=%0d fc=%0d",
                             n, s_x, s_y, s_fc, ex(n, SHT), ey(n, SHT, SVT), ef(n, SHT, SVT));
      end
      checks++;
      if (d_x !== 10'(ex(n, DHT)) || d_y !== 10'(ey(n, DHT, DVT)) || d_hsync !== !inwin(ex(n, DHT), 656, 96)) begin
        failures++; $display("FAIL random_default n=%0d got x=%0d y=%0d exp x=%0d y=%0d", n, d_x, d_y, ex(n, DHT), ey(n, DHT, DVT));
      end
    end
  endtask

  task automatic test_async_reset();
    restart();
    px_en = 1'b1;
    run(SHT * SVT + 15 * SHT + 22);
    checks++; if (s_x !== 10'd22 || s_y !== 10'd15 || s_hsync !== 1'b1 || s_vsync !== 1'b0 || s_fc !== 5'd1) begin
      failures++; $display("FAIL async_pre got x=%0d y=%0d hs=%b vs=%b fc=%0d exp 22,15,1,0,1", s_x, s_y, s_hsync, s_vsync, s_fc);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (s_x !== 10'd0 || s_y !== 10'd0 || s_fc !== 5'd0) begin
      failures++; $display("FAIL async_counters got=%0d,%0d,%0d exp=0,0,0", s_x, s_y, s_fc);
    end
    checks++; if (s_hsync !== 1'b0 || s_vsync !== 1'b1 || d_hsync !== 1'b1 || d_x !== 10'd0) begin
      failures++; $display("FAIL async_sync got s_hs=%b s_vs=%b d_hs=%b d_x=%0d exp 0,1,1,0", s_hsync, s_vsync, d_hsync, d_x);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++; if (s_x !== 10'd1 || d_x !== 10'd1 || s_y !== 10'd0) begin
      failures++; $display("FAIL async_first_advance got s_x=%0d d_x=%0d exp 1,1", s_x, d_x);
    end
  endtask

  initial begin
    test_reset();
    test_hsync_line();
    test_frame();
    test_frame_wrap();
    test_px_en();
    test_random_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that drives the procedural scrolling-background renderer.
- Produces hsync/vsync, pixel coordinates, the active-video flag, line/frame-start strobes and a free-running frame counter, all from one clock.
- The renderer consumes the coordinates directly (256x256 window decode, per-line and per-frame LFSR stepping), so every output is cycle-aligned to the same pixel.
- Defaults give 640x480@60 at a 25.175 MHz pixel rate.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync (0 = active-low)
- VS_POL, 0, active level of vsync (0 = active-low)
- FRAME_W, 5, width of frame_count

Ports:
- clk  input  1  pixel-domain clock
- reset  input  1  asynchronous, active-high reset
- px_en  input  1  pixel advance enable; tie high when clk equals the pixel rate
- hsync  output  1  horizontal sync, polarity per HS_POL
- vsync  output  1  vertical sync, polarity per VS_POL
- x_px  output  10  horizontal position, 0..H_TOTAL-1
- y_px  output  10  vertical position, 0..V_TOTAL-1
- activevideo  output  1  high when x_px<H_ACTIVE and y_px<V_ACTIVE
- line_start  output  1  high while x_px==0
- frame_start  output  1  high while x_px==0 and y_px==0
- frame_count  output  FRAME_W  completed-frame counter

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL likewise (default 525).
  - Both must be ≤1024; an elaboration-time check fails otherwise.
- Clock, reset and enable:
  - Single clock domain. reset is asynchronous and active-high: clk and reset, reset asynchronous active-high.
  - Reset values: x_px=0, y_px=0, frame_count=0, hsync=~HS_POL, vsync=~VS_POL. This gives activevideo=1, line_start=1 and frame_start=1 while counters sit at (0,0).
  - Reset asserted mid-frame returns everything to the reset values immediately, without waiting for a clk edge. The first advance occurs on the first clk edge with px_en=1 after reset deasserts.
  - px_en=0: all registers hold; outputs remain stable.
- Counters (only on a clk edge with px_en=1):
  - x_px increments; at H_TOTAL-1 it wraps to 0.
  - y_px increments only on the x wrap; at V_TOTAL-1 it wraps to 0.
  - frame_count increments only on the simultaneous x and y wrap, i.e. the transition (H_TOTAL-1, V_TOTAL-1) -> (0,0). It wraps modulo 2^FRAME_W.
- Sync outputs:
  - hsync and vsync are registered.
  - Each is computed from the next-state counter values, so on any cycle they correspond to the currently presented x_px/y_px with zero relative latency.
  - hsync is active when H_ACTIVE+H_FP ≤ x_px < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync is active when V_ACTIVE+V_FP ≤ y_px < V_ACTIVE+V_FP+V_SYNC (default 490..491).
  - vsync transitions coincide with x_px==0.
- Decoded outputs:
  - activevideo, line_start and frame_start are decoded from the registered counters.
  - Consumers sample them on clk only; they are not used as clocks.
- Strobe width:
  - A strobe lasts exactly one px_en-qualified pixel.
  - If px_en is low while x_px==0, line_start stays high until the next advance.
- No other state: there is no state machine beyond the two counters and the frame counter.
- Counter out-of-range defence:
  - If a counter is ever ≥ its total (no legal path, but defended), the next advance loads 0.

Test Plan:
1. Reset, then release with px_en=1; after 656 edges -> x_px=656, hsync=0. After 752 edges -> hsync=1. Check activevideo=0 from x_px=640 onward.
2. Run to x_px=799, y_px=0, then one edge -> x_px=0, y_px=1, line_start=1, frame_start=0, frame_count=0.
3. Full-frame run: check vsync=0 exactly for y_px 490..491, i.e. 1600 cycles. Check activevideo=0 for all y_px≥480.
4. Run from (799,524), one edge -> (0,0), frame_start=1, frame_count=1. Preload the frame counter via 32 frames -> frame_count wraps to 0.
5. Toggle px_en at 50% from (10,3) for 20 edges -> x_px=20. Check all outputs are unchanged on the px_en=0 edges.
6. Assert reset asynchronously between edges at (700,491) -> immediately (0,0), hsync=1, vsync=1, frame_count=0, with no clk edge required.
